// File: rtl/cpu_coherence_top.sv
// Four single-line caches kept coherent by snooping MESI over a shared bus.
// Ports: clk, rst, proc_ID, rd_wr, wr_data in; rd_data, hit, bus_op, wb, state0..3 out.

module cpu_coherence_cache #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld,
  input  logic [1:0]        next_state,
  input  logic [DATA_W-1:0] data_in,
  output logic [1:0]        state,
  output logic [DATA_W-1:0] data
);
  typedef enum logic [1:0] {
    I = 2'd0,
    S = 2'd1,
    E = 2'd2,
    M = 2'd3
  } mesi_t;

  mesi_t cachedState;

  always_ff @(posedge clk) begin
    if (rst) begin
      cachedState <= I;
      data        <= '0;
    end else begin
      cachedState <= mesi_t'(next_state);
      if (ld) data <= data_in;
    end
  end

  assign state = cachedState;
endmodule

module cpu_coherence_top #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        proc_ID,
  input  logic              rd_wr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              hit,
  output logic [1:0]        bus_op,
  output logic              wb,
  output logic [1:0]        state0,
  output logic [1:0]        state1,
  output logic [1:0]        state2,
  output logic [1:0]        state3
);
  localparam logic [1:0] ST_I = 2'd0;
  localparam logic [1:0] ST_S = 2'd1;
  localparam logic [1:0] ST_E = 2'd2;
  localparam logic [1:0] ST_M = 2'd3;

  localparam logic [1:0] OP_NONE = 2'd0;
  localparam logic [1:0] OP_RD   = 2'd1;
  localparam logic [1:0] OP_RDX  = 2'd2;
  localparam logic [1:0] OP_UPGR = 2'd3;

  logic [1:0]        st  [4];
  logic [1:0]        nst [4];
  logic [DATA_W-1:0] dat [4];
  logic [3:0]        ld;
  logic [DATA_W-1:0] ld_val;
  logic [DATA_W-1:0] mem, mem_n;
  logic [DATA_W-1:0] rd_n;
  logic              hit_n, wb_n;
  logic [1:0]        op_n;
  logic              req_ok;
  logic              own_m;
  logic [1:0]        owner;
  logic              others_valid;

  // An unknown requester or access type must not disturb any cache.
  assign req_ok = !$isunknown({proc_ID, rd_wr});

  always_comb begin
    for (int i = 0; i < 4; i++) nst[i] = st[i];
    ld           = '0;
    ld_val       = wr_data;
    mem_n        = mem;
    rd_n         = rd_data;
    hit_n        = 1'b0;
    op_n         = OP_NONE;
    wb_n         = 1'b0;
    own_m        = 1'b0;
    owner        = 2'd0;
    others_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (2'(i) != proc_ID) begin
        if (st[i] == ST_M) begin
          own_m = 1'b1;
          owner = 2'(i);
        end
        if (st[i] != ST_I) others_valid = 1'b1;
      end
    end
    if (req_ok) begin
      if (!rd_wr) begin
        if (st[proc_ID] != ST_I) begin
          hit_n = 1'b1;
          rd_n  = dat[proc_ID];
        end else begin
          op_n        = OP_RD;
          ld[proc_ID] = 1'b1;
          ld_val      = mem;
          nst[proc_ID] = ST_S;
          if (own_m) begin
            // Owner flushes; requester takes the fresh copy directly.
            wb_n       = 1'b1;
            mem_n      = dat[owner];
            ld_val     = dat[owner];
            nst[owner] = ST_S;
          end else if (others_valid) begin
            for (int i = 0; i < 4; i++)
              if (2'(i) != proc_ID && st[i] != ST_I) nst[i] = ST_S;
          end else begin
            nst[proc_ID] = ST_E;
          end
          rd_n = ld_val;
        end
      end else begin
        ld[proc_ID]  = 1'b1;
        ld_val       = wr_data;
        rd_n         = wr_data;
        nst[proc_ID] = ST_M;
        unique case (1'b1)
          st[proc_ID] == ST_M,
          st[proc_ID] == ST_E: hit_n = 1'b1;
          st[proc_ID] == ST_S: begin
            hit_n = 1'b1;
            op_n  = OP_UPGR;
          end
          st[proc_ID] == ST_I: begin
            op_n = OP_RDX;
            if (own_m) begin
              wb_n  = 1'b1;
              mem_n = dat[owner];
            end
          end
        endcase
        if (op_n != OP_NONE)
          for (int i = 0; i < 4; i++)
            if (2'(i) != proc_ID) nst[i] = ST_I;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem     <= '0;
      rd_data <= '0;
      hit     <= 1'b0;
      bus_op  <= OP_NONE;
      wb      <= 1'b0;
    end else begin
      mem     <= mem_n;
      rd_data <= rd_n;
      hit     <= hit_n;
      bus_op  <= op_n;
      wb      <= wb_n;
    end
  end

  cpu_coherence_cache #(.DATA_W(DATA_W)) cache0 (
    .clk(clk), .rst(rst), .ld(ld[0]), .next_state(nst[0]),
    .data_in(ld_val), .state(st[0]), .data(dat[0])
  );
  cpu_coherence_cache #(.DATA_W(DATA_W)) cache1 (
    .clk(clk), .rst(rst), .ld(ld[1]), .next_state(nst[1]),
    .data_in(ld_val), .state(st[1]), .data(dat[1])
  );
  cpu_coherence_cache #(.DATA_W(DATA_W)) cache2 (
    .clk(clk), .rst(rst), .ld(ld[2]), .next_state(nst[2]),
    .data_in(ld_val), .state(st[2]), .data(dat[2])
  );
  cpu_coherence_cache #(.DATA_W(DATA_W)) cache3 (
    .clk(clk), .rst(rst), .ld(ld[3]), .next_state(nst[3]),
    .data_in(ld_val), .state(st[3]), .data(dat[3])
  );

  assign state0 = st[0];
  assign state1 = st[1];
  assign state2 = st[2];
  assign state3 = st[3];
endmodule

// File: tb/tb_cpu_coherence_top.sv
// Scoreboard bench for cpu_coherence_top: directed requests, queued expectations.
// A driver pushes expected results; a monitor pops and compares after each edge.

module tb_cpu_coherence_top;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] proc_ID;
  logic       rd_wr;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       hit;
  logic [1:0] bus_op;
  logic       wb;
  logic [1:0] state0, state1, state2, state3;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic [7:0] sts;
    logic [7:0] rd;
    logic       hit;
    logic [1:0] op;
    logic       wb;
    logic [7:0] mem;
  } exp_t;

  exp_t q[$];

  cpu_coherence_top #(.DATA_W(8)) dut (
    .clk(clk), .rst(rst), .proc_ID(proc_ID), .rd_wr(rd_wr),
    .wr_data(wr_data), .rd_data(rd_data), .hit(hit),
    .bus_op(bus_op), .wb(wb), .state0(state0), .state1(state1),
    .state2(state2), .state3(state3)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [7:0] act, logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // sts is {state3, state2, state1, state0}
  task automatic step(logic r, logic [1:0] p, logic w, logic [7:0] d,
                      logic [7:0] sts, logic [7:0] rd, logic h,
                      logic [1:0] op, logic b, logic [7:0] m);
    exp_t e;
    @(negedge clk);
    rst = r; proc_ID = p; rd_wr = w; wr_data = d;
    e.rst = r; e.sts = sts; e.rd = rd; e.hit = h;
    e.op = op; e.wb = b; e.mem = m;
    q.push_back(e);
  endtask

  task automatic do_reset();
    step(1'b1, 2'd0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 2'd0, 1'b0, 8'h00);
  endtask

  initial begin : monitor
    exp_t e;
    int n_me, n_v;
    logic [1:0] s [4];
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("states", {state3, state2, state1, state0}, e.sts);
        chk("probe", {dut.cache3.cachedState, dut.cache2.cachedState,
                      dut.cache1.cachedState, dut.cache0.cachedState}, e.sts);
        chk("rd_data", rd_data, e.rd);
        chk("hit", {7'd0, hit}, {7'd0, e.hit});
        chk("bus_op", {6'd0, bus_op}, {6'd0, e.op});
        chk("wb", {7'd0, wb}, {7'd0, e.wb});
        chk("mem", dut.mem, e.mem);
        if (!e.rst) begin
          s[0] = state0; s[1] = state1; s[2] = state2; s[3] = state3;
          n_me = 0; n_v = 0;
          for (int i = 0; i < 4; i++) begin
            if (s[i] >= 2'd2) n_me++;
            if (s[i] != 2'd0) n_v++;
          end
          checks++;
          if (n_me > 1 || (n_me == 1 && n_v != 1)) begin
            errors++;
            $display("FAIL invariant: states %h, need single M/E owner",
                     {state3, state2, state1, state0});
          end
        end
      end
    end
  end

  initial begin : driver
    rst = 1'b1; proc_ID = 2'd0; rd_wr = 1'b0; wr_data = 8'h00;
    // Write-miss then read-miss with write-back
    do_reset();
    step(0, 2'd1, 1, 8'hA5, 8'h0C, 8'hA5, 0, 2'd2, 0, 8'h00);
    step(0, 2'd0, 0, 8'h00, 8'h05, 8'hA5, 0, 2'd1, 1, 8'hA5);
    step(0, 2'd1, 0, 8'h00, 8'h05, 8'hA5, 1, 2'd0, 0, 8'hA5);
    // Exclusive read then silent upgrade
    do_reset();
    step(0, 2'd2, 0, 8'h00, 8'h20, 8'h00, 0, 2'd1, 0, 8'h00);
    step(0, 2'd2, 1, 8'h3C, 8'h30, 8'h3C, 1, 2'd0, 0, 8'h00);
    step(0, 2'd2, 1, 8'h3C, 8'h30, 8'h3C, 1, 2'd0, 0, 8'h00);
    step(0, 2'd2, 0, 8'h00, 8'h30, 8'h3C, 1, 2'd0, 0, 8'h00);
    // Shared copies, invalidations, upgrade
    do_reset();
    step(0, 2'd0, 0, 8'h00, 8'h02, 8'h00, 0, 2'd1, 0, 8'h00);
    step(0, 2'd1, 0, 8'h00, 8'h05, 8'h00, 0, 2'd1, 0, 8'h00);
    step(0, 2'd3, 1, 8'h11, 8'hC0, 8'h11, 0, 2'd2, 0, 8'h00);
    step(0, 2'd0, 1, 8'h22, 8'h03, 8'h22, 0, 2'd2, 1, 8'h11);
    step(0, 2'd1, 0, 8'h00, 8'h05, 8'h22, 0, 2'd1, 1, 8'h22);
    step(0, 2'd1, 1, 8'h44, 8'h0C, 8'h44, 1, 2'd3, 0, 8'h22);
    step(0, 2'd3, 0, 8'h00, 8'h44, 8'h44, 0, 2'd1, 1, 8'h44);
    // Held write request repeats idempotently
    do_reset();
    step(0, 2'd1, 1, 8'h5A, 8'h0C, 8'h5A, 0, 2'd2, 0, 8'h00);
    step(0, 2'd1, 1, 8'h5A, 8'h0C, 8'h5A, 1, 2'd0, 0, 8'h00);
    step(0, 2'd1, 1, 8'h5A, 8'h0C, 8'h5A, 1, 2'd0, 0, 8'h00);
    // Reset wins over a simultaneous request
    step(1, 2'd1, 1, 8'hFF, 8'h00, 8'h00, 0, 2'd0, 0, 8'h00);
    step(0, 2'd3, 0, 8'h00, 8'h80, 8'h00, 0, 2'd1, 0, 8'h00);
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cpu_coherence_top.md
Name: cpu_coherence_top

Overview:
- Four-processor shared-bus system with one private single-line cache per core, kept coherent by a snooping MESI protocol, plus one backing memory word.
- Each cycle one processor, selected by proc_ID, issues a read or a write to the shared block.
- Top level of the multicore cache design.
- Exposes every cache's MESI state and the bus activity for checking.

Parameters:
- DATA_W, 8, width of the cached data word and of the memory word.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous reset, active-high.
- proc_ID  in  2  index of the requesting processor (0..3).
- rd_wr  in  1  access type: 0 = read, 1 = write.
- wr_data  in  DATA_W  write data for a write request.
- rd_data  out  DATA_W  data returned to the requester; registered.
- hit  out  1  requester held the block valid (S/E/M) before the access; registered.
- bus_op  out  2  bus transaction issued this access: 0 None, 1 BusRd, 2 BusRdX, 3 BusUpgr; registered.
- wb  out  1  a Modified copy was written back to memory during this access; registered.
- state0..state3  out  2 each  MESI state of cache 0..3.

Behaviour:
- Structure:
  - Four cache sub-instances named cache0..cache3.
  - Each holds a 2-bit register cachedState and a DATA_W data register.
  - Hierarchical paths cache<n>.cachedState are mandatory for bench probing.
  - stateN equals cacheN.cachedState.
- Encoding: I=0, S=1, E=2, M=3.
- Reset (rst=1 at clk edge):
  - All cachedState = I; all cache data = 0; memory = 0.
  - rd_data = 0, hit = 0, bus_op = 0, wb = 0.
  - Reset has priority over any request in the same cycle.
- Request model:
  - No valid strobe. When rst=0, one request (proc_ID, rd_wr, wr_data) is sampled and fully completed on every clk edge.
  - All state and outputs update on that same edge: latency 1 cycle.
  - Holding the same request repeats it each cycle; repeats must be idempotent per the rules below.
  - If proc_ID or rd_wr is X/Z, the cycle is treated as a no-op: states hold, bus_op = 0, wb = 0, hit = 0.
- "others" means the three non-requesting caches.
- Read, requester in S/E/M:
  - hit=1, bus_op=None.
  - No state change anywhere; rd_data = own data.
- Read, requester in I:
  - hit=0, bus_op=BusRd.
  - If some other cache is M: that owner writes its data to memory (wb=1) and goes to S. Requester loads that data and goes to S.
  - Else if any other cache is S or E: those caches go to S. Requester loads memory data and goes to S.
  - Else requester loads memory and goes to E.
  - rd_data = loaded value.
- Write, requester in M: hit=1, bus_op=None; data = wr_data; stays M.
- Write, requester in E: hit=1, bus_op=None (silent upgrade); E->M; data = wr_data.
- Write, requester in S: hit=1, bus_op=BusUpgr; all others -> I; requester -> M; data = wr_data.
- Write, requester in I:
  - hit=0, bus_op=BusRdX.
  - Any other M owner writes back to memory (wb=1).
  - All others -> I; requester -> M; data = wr_data.
- On writes, rd_data = wr_data.
- Invariants, checked every cycle after reset:
  - At most one cache in M or E.
  - If any cache is M or E, all others are I.
- Memory is updated only by write-back; a write that stays in cache does not update memory.

Test Plan:
- Reset -> state0..3 = 0, bus_op=0, wb=0, rd_data=0.
- From reset, proc_ID=1, rd_wr=1, wr_data=8'hA5 -> state1=3 (M), others 0, bus_op=2, hit=0, wb=0.
- Then proc_ID=0 read -> wb=1, memory=A5, state0=1, state1=1, rd_data=A5, bus_op=1.
- From reset, proc_ID=2 read -> state2=2 (E), bus_op=1. Then proc_ID=2 write 8'h3C -> state2=3, bus_op=0, hit=1.
- With caches 0,1 in S, proc_ID=3 write 8'h11 -> state3=3, state0/1=0, bus_op=2. Then proc_ID=0 write 8'h22 -> state0=3, state3=0, wb=1, bus_op=2.
- Hold proc_ID=1, rd_wr=1 for 3 cycles after reset -> cycle 1 bus_op=2, later cycles bus_op=0, hit=1, state1 stays 3; assert the invariants every cycle.
